// File: rtl/gray_counter_if.sv
// Control and status bundle for the up/down Gray counter.
// master: drives en/up_dn/load/load_gray; slave: returns gray/binary/tc/sat.
interface gray_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_gray;
  logic [WIDTH-1:0] gray;
  logic [WIDTH-1:0] binary;
  logic             tc;
  logic             sat;

  modport master (
    output en, up_dn, load, load_gray,
    input  gray, binary, tc, sat
  );

  modport slave (
    input  en, up_dn, load, load_gray,
    output gray, binary, tc, sat
  );
endinterface

// File: rtl/gray_counter.sv
// Up/down counter keeping a binary count and a registered Gray view.
// Ports: clk, rst_n (async low), bus (slave): en/up_dn/load/load_gray in; gray/binary/tc/sat out.
module gray_counter #(
  parameter int WIDTH = 4,
  parameter bit WRAP  = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  gray_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAXV = '1;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic [WIDTH-1:0] ld_bin;
  logic             tc_q, tc_d;
  logic             sat_q, sat_d;
  logic             do_load, do_up, do_dn;

  // Binary bit i is the XOR of all Gray bits at or above i.
  always_comb begin
    ld_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ld_bin[i] = ^(bus.load_gray >> i);
    end
  end

  assign do_load = bus.load;
  assign do_up   = !bus.load && bus.en && bus.up_dn;
  assign do_dn   = !bus.load && bus.en && !bus.up_dn;

  always_comb begin
    b_d   = b_q;
    tc_d  = 1'b0;
    sat_d = sat_q;
    unique case (1'b1)
      do_load: begin
        b_d   = ld_bin;
        sat_d = 1'b0;
      end
      do_up: begin
        if (b_q == MAXV) begin
          if (WRAP) begin
            b_d  = '0;
            tc_d = 1'b1;
          end else begin
            sat_d = 1'b1;
          end
        end else begin
          b_d   = b_q + ONE;
          sat_d = 1'b0;
        end
      end
      do_dn: begin
        if (b_q == '0) begin
          if (WRAP) begin
            b_d  = MAXV;
            tc_d = 1'b1;
          end else begin
            sat_d = 1'b1;
          end
        end else begin
          b_d   = b_q - ONE;
          sat_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Gray is registered from the next count so both views stay aligned.
  assign gray_d = b_d ^ (b_d >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q    <= '0;
      gray_q <= '0;
      tc_q   <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      b_q    <= b_d;
      gray_q <= gray_d;
      tc_q   <= tc_d;
      sat_q  <= sat_d;
    end
  end

  assign bus.gray   = gray_q;
  assign bus.binary = b_q;
  assign bus.tc     = tc_q;
  assign bus.sat    = sat_q;

endmodule

// File: tb/tb_gray_counter.sv
// Randomized plus directed bench for gray_counter (WRAP=1 and WRAP=0).
// Both instances see the same stimulus and are checked against a reference model.
module tb_gray_counter;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         up_dn = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] lg = '0;

  always #5 clk = ~clk;

  gray_counter_if #(.WIDTH(W)) ifw ();
  gray_counter_if #(.WIDTH(W)) ifs ();

  assign ifw.en = en;
  assign ifw.up_dn = up_dn;
  assign ifw.load = load;
  assign ifw.load_gray = lg;
  assign ifs.en = en;
  assign ifs.up_dn = up_dn;
  assign ifs.load = load;
  assign ifs.load_gray = lg;

  gray_counter #(.WIDTH(W), .WRAP(1'b1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .bus(ifw.slave)
  );
  gray_counter #(.WIDTH(W), .WRAP(1'b0)) u_sat (
    .clk(clk), .rst_n(rst_n), .bus(ifs.slave)
  );

  int errs = 0;
  int checks = 0;

  int mb[2];
  int mtc[2];
  int msat[2];
  int mwrap[2] = '{1, 0};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inverse Gray by exhaustive search over the code table.
  function automatic int g2b(input int g);
    for (int v = 0; v <= MAXV; v++)
      if ((v ^ (v >> 1)) == g) return v;
    return 0;
  endfunction

  function automatic int b2g(input int v);
    return v ^ (v >> 1);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mb[k] = 0; mtc[k] = 0; msat[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      mtc[k] = 0;
      if (load) begin
        mb[k] = g2b(int'(lg)); msat[k] = 0;
      end else if (en) begin
        int nxt;
        nxt = up_dn ? mb[k] + 1 : mb[k] - 1;
        if (nxt < 0 || nxt > MAXV) begin
          if (mwrap[k] != 0) begin
            mb[k] = (nxt < 0) ? MAXV : 0; mtc[k] = 1;
          end else begin
            msat[k] = 1;
          end
        end else begin
          mb[k] = nxt; msat[k] = 0;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".w.gray"}, 32'(ifw.gray), 32'(b2g(mb[0])));
    chk({tag, ".w.bin"}, 32'(ifw.binary), 32'(mb[0]));
    chk({tag, ".w.tc"}, 32'(ifw.tc), 32'(mtc[0]));
    chk({tag, ".w.sat"}, 32'(ifw.sat), 32'(msat[0]));
    chk({tag, ".s.gray"}, 32'(ifs.gray), 32'(b2g(mb[1])));
    chk({tag, ".s.bin"}, 32'(ifs.binary), 32'(mb[1]));
    chk({tag, ".s.tc"}, 32'(ifs.tc), 32'(mtc[1]));
    chk({tag, ".s.sat"}, 32'(ifs.sat), 32'(msat[1]));
  endtask

  // Apply one set of inputs for one edge, then check 1 ns after it.
  task automatic cycle(input string tag, input logic e, input logic u,
                       input logic l, input logic [W-1:0] g);
    logic [W-1:0] pw, ps;
    int ob0, ob1;
    en = e; up_dn = u; load = l; lg = g;
    pw = ifw.gray; ps = ifs.gray;
    ob0 = mb[0]; ob1 = mb[1];
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
    if (!l && mb[0] != ob0)
      chk({tag, ".w.ham"}, 32'($countones(pw ^ ifw.gray)), 32'd1);
    if (!l && mb[1] != ob1)
      chk({tag, ".s.ham"}, 32'($countones(ps ^ ifs.gray)), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("rst");
    #2;
    rst_n = 1'b1;
  endtask

  logic [3:0] up_seq [16] = '{
    4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
    4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000
  };

  initial begin
    @(posedge clk); #1;
    do_reset();

    for (int i = 0; i < 16; i++) begin
      cycle("up16", 1'b1, 1'b1, 1'b0, '0);
      chk("up16.seq", 32'(ifw.gray), 32'(up_seq[i]));
      chk("up16.tc", 32'(ifw.tc), (i == 15) ? 32'd1 : 32'd0);
    end

    @(negedge clk); do_reset();
    cycle("dn1", 1'b1, 1'b0, 1'b0, '0);
    chk("dn1.gray", 32'(ifw.gray), 32'b1000);
    chk("dn1.bin", 32'(ifw.binary), 32'b1111);
    chk("dn1.tc", 32'(ifw.tc), 32'd1);

    cycle("ld", 1'b0, 1'b1, 1'b1, 4'b1100);
    chk("ld.bin", 32'(ifw.binary), 32'b1000);
    cycle("ldup", 1'b1, 1'b1, 1'b0, '0);
    chk("ldup.gray", 32'(ifw.gray), 32'b1101);
    chk("ldup.tc", 32'(ifw.tc), 32'd0);

    cycle("ld_en", 1'b1, 1'b1, 1'b1, 4'b0101);
    chk("ld_en.bin", 32'(ifw.binary), 32'b0110);

    cycle("satld", 1'b0, 1'b0, 1'b1, 4'b1000);
    for (int i = 0; i < 3; i++) begin
      cycle("satup", 1'b1, 1'b1, 1'b0, '0);
      chk("satup.gray", 32'(ifs.gray), 32'b1000);
      chk("satup.sat", 32'(ifs.sat), 32'd1);
    end
    cycle("hold", 1'b0, 1'b0, 1'b0, '0);
    chk("hold.sat", 32'(ifs.sat), 32'd1);
    cycle("satdn", 1'b1, 1'b0, 1'b0, '0);
    chk("satdn.gray", 32'(ifs.gray), 32'b1001);
    chk("satdn.sat", 32'(ifs.sat), 32'd0);

    @(negedge clk); do_reset();
    for (int i = 0; i < 4; i++) cycle("to0110", 1'b1, 1'b1, 1'b0, '0);
    chk("at0110", 32'(ifw.gray), 32'b0110);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("midrst");
    #1;
    rst_n = 1'b1;
    cycle("postrst", 1'b1, 1'b1, 1'b0, '0);
    chk("postrst.gray", 32'(ifw.gray), 32'b0001);

    en = 1'b0; up_dn = 1'b1; load = 1'b1; lg = 4'b1010;
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("ldrst");
    #1;
    rst_n = 1'b1;
    cycle("ldrst.hold", 1'b0, 1'b0, 1'b0, '0);

    for (int i = 0; i < 400; i++) begin
      cycle("rnd", 1'($urandom_range(0, 3) != 0), 1'($urandom),
            1'($urandom_range(0, 9) == 0), W'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits (legal range 2..16).
REQ-002 Parameter WRAP, default 1; 1 = wrap at range ends, 0 = saturate at range ends.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 en  input  1  count enable; one step per cycle while high.
REQ-006 up_dn  input  1  direction; 1 = up, 0 = down.
REQ-007 load  input  1  synchronous load strobe.
REQ-008 load_gray  input  WIDTH  Gray-coded value captured when load=1.
REQ-009 gray  output  WIDTH  registered Gray-coded count; feeds the downstream Gray-to-binary stage.
REQ-010 binary  output  WIDTH  registered binary equivalent of gray, for cross-check.
REQ-011 tc  output  1  registered terminal-count pulse.
REQ-012 sat  output  1  registered saturation flag, only used when WRAP=0.

Function
REQ-013 Internal state SHALL be a WIDTH-bit binary count b.
REQ-014 gray SHALL equal b XOR (b >> 1) at all times; binary SHALL equal b.
REQ-015 Priority SHALL be load > en > hold.
REQ-016 load=1: b SHALL take the binary decode of load_gray, where bit MSB = g[MSB] and bit i = b[i+1] XOR g[i]; direction and en are ignored; tc=0 and sat=0 that cycle.
REQ-017 load=0, en=1, up_dn=1, b<2^WIDTH-1: b SHALL become b+1.
REQ-018 load=0, en=1, up_dn=0, b>0: b SHALL become b-1.
REQ-019 Up step at b=2^WIDTH-1 with WRAP=1: b SHALL become 0, and tc SHALL be 1 in the same cycle the wrapped value appears.
REQ-020 Down step at b=0 with WRAP=1: b SHALL become 2^WIDTH-1, with tc=1 in the same cycle.
REQ-021 With WRAP=0, an end-of-range step SHALL hold b, set sat=1, and leave tc=0.
REQ-022 sat SHALL clear on the first cycle that b changes (load or a legal step).
REQ-023 tc SHALL be a one-cycle pulse; it is 0 in every cycle with no wrap.
REQ-024 en=0 and load=0: b, tc=0, and sat SHALL all hold.
REQ-025 Latency from input sample to output change SHALL be exactly 1 clock; there is no combinational path from inputs to outputs.
REQ-026 Consecutive gray values produced by steps SHALL differ in exactly one bit, including the wrap step; load is exempt.
REQ-027 A direction change while en=1 SHALL take effect on that same edge, with no dead cycle.

Reset
REQ-028 rst_n=0 SHALL immediately force b=0, gray=0, binary=0, tc=0, sat=0, independent of clk.
REQ-029 Reset asserted mid-count or during load SHALL discard the pending operation.
REQ-030 On the first rising edge after rst_n deasserts, the block SHALL count normally.

Verification (WIDTH=4)
REQ-031 Reset, then en=1, up_dn=1 for 16 cycles -> gray = 0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000; tc=1 only with the final 0000.
REQ-032 From reset, en=1, up_dn=0 for 1 cycle -> gray=1000, binary=1111, tc=1.
REQ-033 load=1, load_gray=1100, then en=1, up_dn=1 for 1 cycle -> gray 1100 (binary 1000), then gray 1101 (binary 1001); tc=0 throughout.
REQ-034 Load and en high together: load=1, load_gray=0101, en=1 -> gray=0101 (binary 0110); the step is ignored.
REQ-035 WRAP=0: load 1000, then en=1, up_dn=1 for 3 cycles -> gray stays 1000, sat=1, tc=0; then up_dn=0 for 1 cycle -> gray=1001, sat=0.
REQ-036 Counting at gray=0110 with rst_n pulsed low between edges -> outputs go to 0 before the next edge; the bench checks one-bit Hamming distance on every step transition.
